// File: rtl/alu_cmd_seq.sv
// ---------------------------------------------------------------------------
// alu_cmd_seq
//
// Command sequencer and result collector for a registered 8-bit ALU.
// Tagged commands are accepted over a valid/ready port. Each accepted command
// drives the ALU operand/opcode registers. A two-stage valid pipeline follows
// the ALU's one-cycle result latency. Each result is captured with its tag
// and opcode into a small response FIFO, which is drained over a second
// valid/ready port.
//
// Handshake rule for both ports: a transfer happens on a rising clock edge
// where valid && ready are both high. valid must not depend on ready.
// cmd_ready is a function of registered state (and rst) only.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid/cmd_ready command handshake
//   cmd_op/a/b/tag      command opcode, operands and tag
//   alu_a/alu_b/alu_s   registered operands/opcode to the ALU
//   alu_y               ALU registered 16-bit result
//   rsp_valid/rsp_ready response handshake (rsp_valid = FIFO non-empty)
//   rsp_y/rsp_op/rsp_tag head-of-FIFO result, opcode and tag
//   busy                any command in flight or buffered
// ---------------------------------------------------------------------------
module alu_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic [7:0]      cmd_a,
    input  logic [7:0]      cmd_b,
    input  logic [TAGW-1:0] cmd_tag,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    output logic [2:0]      alu_s,
    input  logic [15:0]     alu_y,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [15:0]     rsp_y,
    output logic [2:0]      rsp_op,
    output logic [TAGW-1:0] rsp_tag,
    output logic            busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;  // pointer width
    localparam int CW = PW + 1;                           // count width (0..DEPTH)
    localparam int OW = CW + 1;                           // occupancy width (0..DEPTH+2)
    localparam int RW = 16 + 3 + TAGW;                    // FIFO entry width
    localparam logic [OW-1:0] DEPTH_OCC = OW'(DEPTH);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [7:0]      alu_a_q, alu_a_d;
    logic [7:0]      alu_b_q, alu_b_d;
    logic [2:0]      alu_s_q, alu_s_d;

    logic            p1_vld_q, p1_vld_d;
    logic [2:0]      p1_op_q,  p1_op_d;
    logic [TAGW-1:0] p1_tag_q, p1_tag_d;

    logic            p2_vld_q, p2_vld_d;
    logic [2:0]      p2_op_q,  p2_op_d;
    logic [TAGW-1:0] p2_tag_q, p2_tag_d;

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    logic [RW-1:0]   mem_q [DEPTH];

    // -----------------------------------------------------------------------
    // Combinational control
    // -----------------------------------------------------------------------
    logic [OW-1:0] occ;
    logic          accept;
    logic          push;
    logic          pop;
    logic [RW-1:0] push_entry;
    logic [RW-1:0] head_entry;

    always_comb begin
        // Occupancy counts results already buffered plus the ones still in
        // the pipeline, so every accepted command has a FIFO slot reserved.
        // A pop in the same cycle is deliberately not credited.
        occ       = OW'(count_q) + OW'(p1_vld_q) + OW'(p2_vld_q);
        cmd_ready = !rst && (occ < DEPTH_OCC);
        accept    = cmd_valid && cmd_ready;
        rsp_valid = (count_q != '0);
        pop       = rsp_valid && rsp_ready;
        // alu_y was registered by the ALU on the edge where p2 loaded.
        push      = p2_vld_q;
        push_entry = {alu_y, p2_op_q, p2_tag_q};
        head_entry = mem_q[rd_ptr_q];
        busy      = (occ != '0);
    end

    always_comb begin
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_s_d  = alu_s_q;
        p1_vld_d = accept;
        p1_op_d  = p1_op_q;
        p1_tag_d = p1_tag_q;
        p2_vld_d = p1_vld_q;
        p2_op_d  = p1_op_q;
        p2_tag_d = p1_tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (accept) begin
            alu_a_d  = cmd_a;
            alu_b_d  = cmd_b;
            alu_s_d  = cmd_op;
            p1_op_d  = cmd_op;
            p1_tag_d = cmd_tag;
        end

        // DEPTH is a power of two, so natural pointer overflow is the wrap.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_s_q  <= '0;
            p1_vld_q <= 1'b0;
            p1_op_q  <= '0;
            p1_tag_q <= '0;
            p2_vld_q <= 1'b0;
            p2_op_q  <= '0;
            p2_tag_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_s_q  <= alu_s_d;
            p1_vld_q <= p1_vld_d;
            p1_op_q  <= p1_op_d;
            p1_tag_q <= p1_tag_d;
            p2_vld_q <= p2_vld_d;
            p2_op_q  <= p2_op_d;
            p2_tag_q <= p2_tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage carries no reset; only pointers and count define validity.
    // The occupancy bound guarantees a push never lands on the head entry, so
    // the head stays stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_s   = alu_s_q;
    assign rsp_y   = head_entry[RW-1 -: 16];
    assign rsp_op  = head_entry[TAGW +: 3];
    assign rsp_tag = head_entry[TAGW-1:0];

endmodule

// File: tb/tb_alu_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_seq
//
// Bench for alu_cmd_seq. A behavioural registered ALU sits on the alu_* port.
// The driver pushes {y, op, tag} into exp_q when a command is accepted. An
// independent monitor pops and compares on every response transfer, and it
// also checks that the head fields hold steady across stalled cycles.
//
// ALU opcodes used by the behavioural ALU:
//   0 a+b, 1 a-b, 2 a*b, 3 ~a, 4 a>b, 5 a<b, 6 a&b, 7 a|b (16-bit results)
// ---------------------------------------------------------------------------
module tb_alu_cmd_seq;

  localparam int TAGW = 4;
  localparam int W    = 16 + 3 + TAGW;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [7:0]      cmd_a;
  logic [7:0]      cmd_b;
  logic [TAGW-1:0] cmd_tag;
  logic [7:0]      alu_a;
  logic [7:0]      alu_b;
  logic [2:0]      alu_s;
  logic [15:0]     alu_y;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [15:0]     rsp_y;
  logic [2:0]      rsp_op;
  logic [TAGW-1:0] rsp_tag;
  logic            busy;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int run_len = 0;
  int max_run = 0;
  logic rand_ready = 1'b0;

  alu_cmd_seq #(.DEPTH(4), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_op(rsp_op), .rsp_tag(rsp_tag),
    .busy(busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference ALU function ----------------
  function automatic logic [15:0] ref_alu(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      3'd0: ref_alu = {8'h00, a} + {8'h00, b};
      3'd1: ref_alu = {8'h00, a} - {8'h00, b};
      3'd2: ref_alu = {8'h00, a} * {8'h00, b};
      3'd3: ref_alu = ~{8'h00, a};
      3'd4: ref_alu = (a > b) ? 16'd1 : 16'd0;
      3'd5: ref_alu = (a < b) ? 16'd1 : 16'd0;
      3'd6: ref_alu = {8'h00, a & b};
      default: ref_alu = {8'h00, a | b};
    endcase
  endfunction

  // Behavioural registered ALU
  always @(posedge clk) alu_y <= ref_alu(alu_s, alu_a, alu_b);

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Holds cmd_valid high until accepted; leaves it high for back-to-back use.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [TAGW-1:0] tag, input logic [15:0] y);
    int n;
    cmd_valid = 1'b1;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
    n = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 200) begin
        check("send_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    exp_q.push_back({y, op, tag});
    #1;
  endtask

  task automatic idle(input int cycles);
    cmd_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    cmd_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    check("drain_busy", busy, 0);
    check("drain_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- random ready driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic            held_valid = 1'b0;
  logic [W-1:0]    held_fields;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst) begin
      held_valid = 1'b0;
      run_len = 0;
    end else begin
      if (rsp_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (held_valid && rsp_valid) check("stall_stable", {rsp_y, rsp_op, rsp_tag}, held_fields);
      held_valid  = rsp_valid && !rsp_ready;
      held_fields = {rsp_y, rsp_op, rsp_tag};
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", {rsp_y, rsp_op, rsp_tag}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("rsp", {rsp_y, rsp_op, rsp_tag}, e);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] y;
  } vec_t;

  vec_t corners[5];
  vec_t full_v[6];
  int   acc;

  initial begin
    corners[0] = '{3'd1, 8'd5,   8'd10,  16'hFFFB};
    corners[1] = '{3'd2, 8'd255, 8'd255, 16'hFE01};
    corners[2] = '{3'd3, 8'h0F,  8'h00,  16'hFFF0};
    corners[3] = '{3'd4, 8'd9,   8'd3,   16'h0001};
    corners[4] = '{3'd5, 8'd9,   8'd3,   16'h0000};
    full_v[0]  = '{3'd0, 8'd1,   8'd2,   16'h0003};
    full_v[1]  = '{3'd1, 8'd50,  8'd7,   16'h002B};
    full_v[2]  = '{3'd2, 8'd16,  8'd16,  16'h0100};
    full_v[3]  = '{3'd6, 8'hF0,  8'h3C,  16'h0030};
    full_v[4]  = '{3'd7, 8'hA0,  8'h05,  16'h00A5};
    full_v[5]  = '{3'd0, 8'd255, 8'd1,   16'h0100};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_cmd_ready", cmd_ready, 0);
    check("reset_alu_a", alu_a, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single add with latency check
    send(3'd0, 8'd200, 8'd100, 4'd3, 16'h012C);
    cmd_valid = 1'b0;
    @(negedge clk); check("lat_e0_valid", rsp_valid, 0);
    @(negedge clk); check("lat_e1_valid", rsp_valid, 0);
    @(negedge clk); check("lat_e2_valid", rsp_valid, 1);
    check("lat_y", rsp_y, 16'h012C);
    check("lat_tag", rsp_tag, 3);
    @(negedge clk); check("busy_after_pop", busy, 0);
    @(posedge clk); #1;

    // Back-to-back arithmetic corners
    max_run = 0;
    for (int i = 0; i < 5; i++)
      send(corners[i].op, corners[i].a, corners[i].b, 4'(i), corners[i].y);
    drain();
    check("b2b_run", max_run, 5);

    // Full: consumer stalled, 6 offered, 4 accepted
    rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      if (acc < 6) begin
        cmd_valid = 1'b1;
        cmd_op = full_v[acc].op; cmd_a = full_v[acc].a; cmd_b = full_v[acc].b; cmd_tag = 4'(acc + 8);
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
      if (cmd_valid && cmd_ready) begin
        @(posedge clk);
        exp_q.push_back({full_v[acc].y, full_v[acc].op, 4'(acc + 8)});
        acc++;
      end else begin
        @(posedge clk);
      end
      #1;
    end
    @(negedge clk);
    check("full_accepted", acc, 4);
    check("full_cmd_ready", cmd_ready, 0);
    check("full_busy", busy, 1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    for (int i = 4; i < 6; i++)
      send(full_v[i].op, full_v[i].a, full_v[i].b, 4'(i + 8), full_v[i].y);
    drain();

    // Simultaneous push/pop across pointer wrap
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(3'd1, 8'(40 + i), 8'(i * 3), 4'(i), ref_alu(3'd1, 8'(40 + i), 8'(i * 3)));
    idle(4);
    rsp_ready = 1'b1;
    for (int i = 3; i < 15; i++)
      send(3'd1, 8'(i * 7), 8'(100 - i), 4'(i), ref_alu(3'd1, 8'(i * 7), 8'(100 - i)));
    drain();

    // Stall stability with pseudo-random consumer
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [2:0] op;
      logic [7:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      send(op, a, b, 4'(i), ref_alu(op, a, b));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    cmd_valid = 1'b0;
    rand_ready = 1'b0;
    @(posedge clk); #1 rsp_ready = 1'b1;
    drain();

    // Reset mid-operation: 2 buffered, 2 in flight
    rsp_ready = 1'b0;
    send(3'd0, 8'd1, 8'd1, 4'd1, 16'h0002);
    send(3'd0, 8'd2, 8'd2, 4'd2, 16'h0004);
    idle(2);
    send(3'd2, 8'd3, 8'd3, 4'd3, 16'h0009);
    send(3'd7, 8'd4, 8'd1, 4'd4, 16'h0005);
    rst = 1'b1;
    cmd_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_alu_s", alu_s, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    rsp_ready = 1'b1;
    send(3'd0, 8'd20, 8'd22, 4'd9, 16'h002A);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_cmd_seq.md
# alu_cmd_seq

Command sequencer and result collector that acts as the initiator for the registered 8-bit ALU (opcode 3 bits, operands 8 bits, 16-bit registered result). It accepts tagged commands over a valid/ready interface and drives the ALU operand and opcode inputs. It tracks the ALU's one-cycle result latency in a 2-stage pipeline, captures each result, and returns it with its tag through a small response FIFO with valid/ready back-pressure.

## Interface
- DEPTH, 4, response FIFO entries; a power of 2, at least 2
- TAGW, 4, command/response tag width
- clk  in  1  sole clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command can be accepted this cycle
- cmd_op  in  3  ALU opcode
- cmd_a  in  8  operand a
- cmd_b  in  8  operand b
- cmd_tag  in  TAGW  command tag, returned with the result
- alu_a  out  8  registered operand a to the ALU
- alu_b  out  8  registered operand b to the ALU
- alu_s  out  3  registered opcode to the ALU
- alu_y  in  16  ALU registered result
- rsp_valid  out  1  FIFO non-empty
- rsp_ready  in  1  consumer takes head entry
- rsp_y  out  16  head result
- rsp_op  out  3  head opcode
- rsp_tag  out  TAGW  head tag
- busy  out  1  any command in flight or buffered

## Operation
- Accept occurs when cmd_valid && cmd_ready. On accept, alu_a/alu_b/alu_s load cmd_a/cmd_b/cmd_op. Stage-1 valid p1 is set and carries tag/op.
- With no accept, alu_a/alu_b/alu_s hold their last value and p1 clears.
- Stage 2 (p2) copies stage 1 every cycle.
- While p2 is set, alu_y (registered by the ALU on the edge where p2 loaded) is pushed into the FIFO with stage-2 tag/op.
- Occupancy occ = fifo_count + p1 + p2.
- cmd_ready = !rst && (occ < DEPTH). It is combinational from registered state only. The same-cycle pop is not credited, which is conservative. The FIFO therefore can never overflow.
- FIFO pop on rsp_valid && rsp_ready. rsp_y/rsp_op/rsp_tag show the head entry and must stay stable while rsp_valid && !rsp_ready.
- Simultaneous push and pop: count unchanged; both pointers advance; wrap-around is modulo DEPTH.
- busy = (occ != 0).
- Result values are whatever alu_y carries. The block performs no arithmetic.
- The ALU reset is owned at top level. The sequencer assumes the ALU is out of reset whenever p2 is set.

## Timing
- Reset (rst high at an edge) clears alu_a/alu_b/alu_s to 0, p1/p2 to 0, and FIFO pointers/count to 0.
- During reset: rsp_valid 0, busy 0, cmd_ready 0.
- An accept in the cycle reset is asserted is ignored. A command mid-flight at reset is discarded, not returned.
- Latency: command accepted at edge E0 → ALU latches result at E1 → FIFO push at E2 → rsp_valid high in the cycle after E2, when the FIFO was empty. Accept to rsp_valid is 3 edges, assuming rsp_ready is high.
- Throughput: one command per cycle sustained while the consumer holds rsp_ready high. Back-to-back results emerge on consecutive cycles.
- Order: responses return strictly in acceptance order.
- Back-pressure: with rsp_ready low, at most DEPTH commands are accepted. cmd_ready then stays low until a pop occurs. After a pop, cmd_ready rises in the next cycle.

## Test plan
- Reset then single add: a=200, b=100, op=000, tag=3. Required: rsp_valid rises 3 edges after accept with rsp_y=0x012C, rsp_tag=3. busy then falls after the pop.
- Arithmetic corners, back-to-back:
  - sub 5-10 → 0xFFFB
  - mul 255*255 → 0xFE01
  - ~a, a=0x0F → 0xFFF0
  - a>b, 9>3 → 0x0001
  - a<b, 9<3 → 0x0000

  Required: five consecutive rsp_valid cycles, tags 0-4 in order.
- Full: rsp_ready held low, 6 commands offered. Required: exactly 4 accepted and cmd_ready low afterwards. Raise rsp_ready: results arrive in order, and the remaining 2 commands are accepted after pops.
- Simultaneous push/pop: FIFO holds 3 entries, stream continues with rsp_ready=1. Required: count stays constant, no data loss or duplication across pointer wrap (≥10 commands).
- Stall stability: rsp_ready toggled pseudo-randomly. Required: head fields stable while stalled, and scoreboard matches a reference model.
- Reset mid-operation: assert rst with 2 commands in flight and 2 buffered. Required: next cycle rsp_valid=0, busy=0, alu_s=0. After release, a new command returns only its own result.
